if_pc_sel_ctrl: RTL and testbench

- Sequences the IF-stage 32-bit PC-source mux (sel=0 → PC+4, sel=1 → redirect target) and the IF/ID and ID/EX pipeline register controls.
- Detects load-use hazards, holds the pipe for memory wait, and turns EX-stage taken branches/jumps into a registered two-cycle redirect.
- Sits between the hazard inputs (ID/EX decode fields, EX branch unit, memory stage) and the IF mux, PC register and pipeline registers.

---
 rtl/if_pc_sel_ctrl_pkg.sv | 14 +
 rtl/if_pc_sel_ctrl.sv | 90 +++++++++
 tb/tb_if_pc_sel_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/if_pc_sel_ctrl_pkg.sv
// Shared IF-stage constants: PC mux select codes, controller state encoding,
// and the hard-wired zero register address.
package if_pc_sel_ctrl_pkg;

    localparam logic       PC_SEL_SEQ   = 1'b0;
    localparam logic       PC_SEL_REDIR = 1'b1;
    localparam logic [4:0] REG_ZERO     = 5'd0;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } state_e;

endpackage

// File: rtl/if_pc_sel_ctrl.sv
// IF PC-source and pipeline-register control: load-use bubbles, memory-wait
// freeze, and a registered two-cycle redirect for taken branches/jumps.
module if_pc_sel_ctrl
    import if_pc_sel_ctrl_pkg::*;
#(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    input  logic              mem_busy,
    output logic              pc_sel,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [PC_W-1:0]   r_redirect_pc;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_load_use;
    logic              w_latch_target;

    assign w_load_use = ex_memread && (ex_rt != REG_ZERO) &&
                        ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Priority: rst, mem_busy, pending redirect, new branch, load-use.
    always_comb begin
        pc_sel         = PC_SEL_SEQ;
        pc_we          = 1'b1;
        ifid_we        = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        w_state_nxt    = r_state;
        w_latch_target = 1'b0;
        if (rst) begin
            w_state_nxt = ST_RUN;
        end else if (mem_busy) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            pc_sel  = (r_state == ST_REDIRECT) ? PC_SEL_REDIR : PC_SEL_SEQ;
        end else if (r_state == ST_REDIRECT) begin
            pc_sel      = PC_SEL_REDIR;
            ifid_flush  = 1'b1;
            w_state_nxt = ST_RUN;
        end else if (br_taken) begin
            pc_we          = 1'b0;
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            w_latch_target = 1'b1;
            w_state_nxt    = ST_REDIRECT;
        end else if (w_load_use) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_redirect_pc <= '0;
            r_stall_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch_target) begin
                r_redirect_pc <= br_target;
            end
            if (!pc_we && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign redirect_pc = r_redirect_pc;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_if_pc_sel_ctrl.sv
// Directed bench for if_pc_sel_ctrl with hand-computed expectations.
module tb_if_pc_sel_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_memread;
    logic [4:0]  ex_rt;
    logic        br_taken;
    logic [31:0] br_target;
    logic        mem_busy;
    logic        pc_sel;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_flush;
    logic [31:0] redirect_pc;
    logic [15:0] stall_cnt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    if_pc_sel_ctrl #(
        .PC_W   (32),
        .REG_AW (5),
        .CNT_W  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_memread  (ex_memread),
        .ex_rt       (ex_rt),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .mem_busy    (mem_busy),
        .pc_sel      (pc_sel),
        .pc_we       (pc_we),
        .ifid_we     (ifid_we),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .redirect_pc (redirect_pc),
        .stall_cnt   (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; combinational outputs are
    // checked mid-cycle, registered outputs right after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic ctl(input string tag, input logic e_sel, input logic e_pcwe,
                       input logic e_ifidwe, input logic e_ifidfl, input logic e_idexfl);
        chk({tag, ".pc_sel"},     {31'd0, pc_sel},     {31'd0, e_sel});
        chk({tag, ".pc_we"},      {31'd0, pc_we},      {31'd0, e_pcwe});
        chk({tag, ".ifid_we"},    {31'd0, ifid_we},    {31'd0, e_ifidwe});
        chk({tag, ".ifid_flush"}, {31'd0, ifid_flush}, {31'd0, e_ifidfl});
        chk({tag, ".idex_flush"}, {31'd0, idex_flush}, {31'd0, e_idexfl});
    endtask

    initial begin
        rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_memread = 1'b0;
        ex_rt = '0; br_taken = 1'b0; br_target = '0; mem_busy = 1'b0;

        // Reset for two cycles
        tick();
        mid(); ctl("rst_cyc", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        chk("rst.redirect_pc", redirect_pc, 32'h0);
        chk("rst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        mid(); ctl("post_rst", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();

        // Branch redirect
        br_taken = 1'b1; br_target = 32'h0000_0040;
        mid(); ctl("br.N", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        br_taken = 1'b0; br_target = 32'hDEAD_BEEF;
        chk("br.redirect_pc", redirect_pc, 32'h40);
        chk("br.cnt_N1", {16'd0, stall_cnt}, 32'd1);
        mid(); ctl("br.N1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        mid(); ctl("br.N2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("br.cnt_N2", {16'd0, stall_cnt}, 32'd1);
        tick();

        // Load-use on rs: exactly one bubble
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        mid(); ctl("lu.rs", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        ex_memread = 1'b0;
        chk("lu.cnt", {16'd0, stall_cnt}, 32'd2);
        mid(); ctl("lu.after", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        // ex_rt = 0 never stalls
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        mid(); ctl("lu.r0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        // rt match with rt unused: no stall
        ex_rt = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
        mid(); ctl("lu.rt_unused", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        // rt match with rt used: stall
        id_uses_rt = 1'b1;
        mid(); ctl("lu.rt_used", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        ex_memread = 1'b0; id_uses_rt = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
        chk("lu.cnt2", {16'd0, stall_cnt}, 32'd3);

        // Memory wait during redirect
        br_taken = 1'b1; br_target = 32'h0000_0100;
        mid(); ctl("mw.N", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        br_target = 32'h0000_0200; mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid(); ctl("mw.busy", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("mw.redirect_pc", redirect_pc, 32'h100);
        mem_busy = 1'b0; br_target = 32'h0000_0300;
        mid(); ctl("mw.N4", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("mw.cnt", {16'd0, stall_cnt}, 32'd7);
        tick();
        br_taken = 1'b0;
        chk("mw.redirect_pc_hold", redirect_pc, 32'h100);
        mid(); ctl("mw.N5", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();

        // Branch and load-use together: branch only, no extra bubble
        br_taken = 1'b1; br_target = 32'h0000_0080;
        ex_memread = 1'b1; ex_rt = 5'd7; id_rs = 5'd7;
        mid(); ctl("sim.N", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        br_taken = 1'b0;
        mid(); ctl("sim.N1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        ex_memread = 1'b0; ex_rt = '0; id_rs = '0;
        mid(); ctl("sim.N2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("sim.cnt", {16'd0, stall_cnt}, 32'd8);
        chk("sim.redirect_pc", redirect_pc, 32'h80);
        tick();

        // Reset in the middle of a redirect
        br_taken = 1'b1; br_target = 32'h0000_0044;
        tick();
        br_taken = 1'b0; rst = 1'b1;
        mid(); ctl("rstmid.N1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        chk("rstmid.redirect_pc", redirect_pc, 32'h0);
        chk("rstmid.cnt", {16'd0, stall_cnt}, 32'd0);
        mid(); ctl("rstmid.run", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();

        // Counter saturation
        mem_busy = 1'b1;
        repeat (65534) tick();
        chk("sat.fffe", {16'd0, stall_cnt}, 32'h0000_FFFE);
        tick();
        chk("sat.ffff", {16'd0, stall_cnt}, 32'h0000_FFFF);
        repeat (4465) tick();
        chk("sat.hold", {16'd0, stall_cnt}, 32'h0000_FFFF);
        mem_busy = 1'b0;
        mid(); ctl("sat.run", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("sat.final", {16'd0, stall_cnt}, 32'h0000_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
